// File: rtl/mem_stage_unit.sv
// M-stage memory unit: byte-enable stores, aligned/extended loads, latency FSM
// with pipeline stall, M/W write-back register, alignment errors and store trace.
module mem_stage_unit #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned MEM_LAT     = 0,
  parameter int unsigned BIG_ENDIAN  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_instr,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [31:0] m_wd,
  input  logic [4:0]  m_a3,
  output logic        m_stall,
  output logic [31:0] w_wd,
  output logic [4:0]  w_a3,
  output logic        w_adel,
  output logic        w_ades,
  output logic        tr_we,
  output logic [31:0] tr_pc,
  output logic [31:0] tr_addr,
  output logic [31:0] tr_data
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          is_ld, is_st, sext;
  logic [1:0]    size;
  logic          aligned, ld, st, access, adel, ades, complete;
  logic [AW-1:0] idx;
  logic [31:0]   rdata, wrep, merged, ext;
  logic [1:0]    bpos;
  logic          hpos;
  logic [3:0]    be;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  // Opcode decode: size 0=byte, 1=half, 2=word
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sext  = 1'b0;
    size  = 2'd2;
    unique case (m_instr[31:26])
      6'h20: begin is_ld = 1'b1; size = 2'd0; sext = 1'b1; end
      6'h21: begin is_ld = 1'b1; size = 2'd1; sext = 1'b1; end
      6'h23: begin is_ld = 1'b1; size = 2'd2; end
      6'h24: begin is_ld = 1'b1; size = 2'd0; end
      6'h25: begin is_ld = 1'b1; size = 2'd1; end
      6'h28: begin is_st = 1'b1; size = 2'd0; end
      6'h29: begin is_st = 1'b1; size = 2'd1; end
      6'h2B: begin is_st = 1'b1; size = 2'd2; end
      default: ;
    endcase
  end

  assign aligned  = (size == 2'd2) ? (m_addr[1:0] == 2'b00) :
                    (size == 2'd1) ? !m_addr[0] : 1'b1;
  assign ld       = m_valid && is_ld;
  assign st       = m_valid && is_st;
  assign access   = (ld || st) && aligned;
  assign adel     = ld && !aligned;
  assign ades     = st && !aligned;
  assign m_stall  = (state == S_BUSY) || ((state == S_IDLE) && access && (MEM_LAT != 0));
  assign complete = access && ((state == S_DONE) || ((state == S_IDLE) && (MEM_LAT == 0)));

  assign idx   = AW'(m_addr[31:2] % 30'(DEPTH_WORDS));
  assign rdata = mem[idx];

  // Physical lane of the addressed byte/half within the stored word
  assign bpos   = (BIG_ENDIAN != 0) ? ~m_addr[1:0] : m_addr[1:0];
  assign hpos   = (BIG_ENDIAN != 0) ? ~m_addr[1] : m_addr[1];
  assign byte_v = rdata[{bpos, 3'b000} +: 8];
  assign half_v = rdata[{hpos, 4'b0000} +: 16];

  always_comb begin
    ext = rdata;
    unique case (size)
      2'd0:    ext = sext ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      2'd1:    ext = sext ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      default: ext = rdata;
    endcase
  end

  // Replicated store data lands in the right lanes for either endianness
  always_comb begin
    be   = 4'hF;
    wrep = m_wdata;
    unique case (size)
      2'd0: begin
        be       = 4'h0;
        be[bpos] = 1'b1;
        wrep     = {4{m_wdata[7:0]}};
      end
      2'd1: begin
        be                = 4'h0;
        be[{hpos, 1'b0}]  = 1'b1;
        be[{hpos, 1'b1}]  = 1'b1;
        wrep              = {2{m_wdata[15:0]}};
      end
      default: ;
    endcase
    for (int k = 0; k < 4; k++)
      merged[k*8 +: 8] = be[k] ? wrep[k*8 +: 8] : rdata[k*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (complete && st) mem[idx] <= merged;
  end

  // Access FSM, W register and store trace
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      w_wd    <= '0;
      w_a3    <= '0;
      w_adel  <= 1'b0;
      w_ades  <= 1'b0;
      tr_we   <= 1'b0;
      tr_pc   <= '0;
      tr_addr <= '0;
      tr_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (access && (MEM_LAT != 0)) begin
            if (MEM_LAT == 1) begin
              state <= S_DONE;
            end else begin
              state <= S_BUSY;
              cnt   <= CW'(MEM_LAT - 1);
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (m_stall) begin
        w_a3   <= '0;
        w_adel <= 1'b0;
        w_ades <= 1'b0;
      end else begin
        w_wd   <= (ld && aligned) ? ext : m_wd;
        w_a3   <= (m_valid && !adel && !ades) ? m_a3 : 5'd0;
        w_adel <= adel;
        w_ades <= ades;
      end

      tr_we <= complete && st;
      if (complete && st) begin
        tr_pc   <= m_pc;
        tr_addr <= {m_addr[31:2], 2'b00};
        tr_data <= merged;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: two configurations (LE single-cycle,
// BE with 3 wait cycles) driven by directed and random memory instructions.
module tb_mem_stage_unit;

  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int       n_cmp = 0;
  int       n_bad = 0;
  bit [1:0] fin   = 2'b00;

  typedef struct {
    int          stalls;
    logic [31:0] wd;
    logic [4:0]  a3;
    logic        adel, ades, trwe, chk_wd;
    logic [31:0] tpc, taddr, tdata;
  } exp_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [5:0] opc(input int k);
    logic [5:0] t [9];
    t = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00};
    return t[k];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int unsigned LAT = (g == 0) ? 0 : 3;
    localparam int unsigned BE  = g;

    logic        reset, m_valid, m_stall, w_adel, w_ades, tr_we;
    logic [31:0] m_instr, m_pc, m_addr, m_wdata, m_wd, w_wd, tr_pc, tr_addr, tr_data;
    logic [4:0]  m_a3, w_a3;

    mem_stage_unit #(.DEPTH_WORDS(DEPTH), .MEM_LAT(LAT), .BIG_ENDIAN(BE)) dut (
      .clk(clk), .reset(reset), .m_valid(m_valid), .m_instr(m_instr), .m_pc(m_pc),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_wd(m_wd), .m_a3(m_a3), .m_stall(m_stall),
      .w_wd(w_wd), .w_a3(w_a3), .w_adel(w_adel), .w_ades(w_ades), .tr_we(tr_we),
      .tr_pc(tr_pc), .tr_addr(tr_addr), .tr_data(tr_data)
    );

    bit [7:0] mb [DEPTH*4];
    exp_t     q[$];
    bit       run = 0, drv_done = 0, mon_done = 0;

    // Word as seen by the memory, assembled from the byte-addressed model
    function automatic logic [31:0] mword(input int widx);
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++)
        if (BE != 0) w = (w << 8) | 32'(mb[widx*4 + i]);
        else         w = w | (32'(mb[widx*4 + i]) << (8*i));
      return w;
    endfunction

    task automatic wait_free();
      int c = 0;
      while (1) begin
        @(negedge clk);
        if (!m_stall) break;
        c++;
        if (c > 40) begin
          $display("FAIL cfg%0d stall_timeout: got stall stuck want release", g);
          $fatal(1);
        end
      end
      @(posedge clk);
      #1;
    endtask

    task automatic issue(input int k, input bit v, input logic [31:0] a, input logic [31:0] wdv);
      exp_t e;
      int   sz, base, widx;
      bit   ld, st, mis;
      logic [31:0] val;
      m_valid = v;
      m_instr = {opc(k), 26'($urandom)};
      m_pc    = $urandom;
      m_addr  = a;
      m_wdata = wdv;
      m_wd    = $urandom;
      m_a3    = 5'($urandom_range(1, 31));
      ld   = v && (k <= 4);
      st   = v && (k >= 5) && (k <= 7);
      sz   = (k == 2 || k == 7) ? 4 : (k == 1 || k == 4 || k == 6) ? 2 : 1;
      mis  = (ld || st) && (a % sz != 0);
      widx = int'((a >> 2) % DEPTH);
      base = widx*4 + int'(a % 4);
      e.stalls = ((ld || st) && !mis) ? LAT : 0;
      e.a3     = (v && !mis) ? m_a3 : 5'd0;
      e.adel   = ld && mis;
      e.ades   = st && mis;
      e.wd     = m_wd;
      e.chk_wd = !mis;
      e.trwe   = 1'b0;
      e.tpc    = '0;
      e.taddr  = '0;
      e.tdata  = '0;
      if (ld && !mis) begin
        val = '0;
        for (int i = 0; i < sz; i++)
          if (BE != 0) val = (val << 8) | 32'(mb[base + i]);
          else         val = val | (32'(mb[base + i]) << (8*i));
        if (k == 0) val = 32'($signed(val[7:0]));
        if (k == 1) val = 32'($signed(val[15:0]));
        e.wd = val;
      end
      if (st && !mis) begin
        for (int i = 0; i < sz; i++)
          mb[base + i] = (BE != 0) ? wdv[8*(sz-1-i) +: 8] : wdv[8*i +: 8];
        e.trwe  = 1'b1;
        e.tpc   = m_pc;
        e.taddr = {a[31:2], 2'b00};
        e.tdata = mword(widx);
      end
      q.push_back(e);
      wait_free();
    endtask

    // Monitor: every stalled cycle must bubble W; every free cycle retires one entry
    initial begin
      exp_t e;
      int   stc = 0;
      bit   s;
      wait (run);
      while (!(drv_done && q.size() == 0)) begin
        @(negedge clk);
        s = m_stall;
        @(posedge clk);
        #1;
        if (s) begin
          stc++;
          check($sformatf("cfg%0d bubble_a3", g), 32'(w_a3), 32'd0);
          check($sformatf("cfg%0d bubble_tr_we", g), 32'(tr_we), 32'd0);
        end else if (q.size() != 0) begin
          e = q.pop_front();
          check($sformatf("cfg%0d stall_cycles", g), 32'(stc), 32'(e.stalls));
          check($sformatf("cfg%0d w_a3", g), 32'(w_a3), 32'(e.a3));
          check($sformatf("cfg%0d w_adel", g), 32'(w_adel), 32'(e.adel));
          check($sformatf("cfg%0d w_ades", g), 32'(w_ades), 32'(e.ades));
          check($sformatf("cfg%0d tr_we", g), 32'(tr_we), 32'(e.trwe));
          if (e.chk_wd) check($sformatf("cfg%0d w_wd", g), w_wd, e.wd);
          if (e.trwe) begin
            check($sformatf("cfg%0d tr_addr", g), tr_addr, e.taddr);
            check($sformatf("cfg%0d tr_data", g), tr_data, e.tdata);
            check($sformatf("cfg%0d tr_pc", g), tr_pc, e.tpc);
          end
          stc = 0;
        end
      end
      mon_done = 1;
    end

    initial begin
      logic [31:0] keep;
      reset = 1'b0; m_valid = 1'b0; m_instr = '0; m_pc = '0;
      m_addr = '0; m_wdata = '0; m_wd = '0; m_a3 = '0;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("cfg%0d rst_w_wd", g), w_wd, 32'd0);
      check($sformatf("cfg%0d rst_w_a3", g), 32'(w_a3), 32'd0);
      check($sformatf("cfg%0d rst_err", g), 32'({w_adel, w_ades}), 32'd0);
      check($sformatf("cfg%0d rst_tr", g), 32'(tr_we) | tr_pc | tr_addr | tr_data, 32'd0);
      check($sformatf("cfg%0d rst_stall", g), 32'(m_stall), 32'd0);
      reset = 1'b1;
      run   = 1;
      // Directed: lane selection, extension, byte merge, errors, wrap
      issue(7, 1, 32'h10, 32'h12345678);
      issue(0, 1, 32'h11, 32'h0);
      issue(3, 1, 32'h13, 32'h0);
      issue(1, 1, 32'h12, 32'h0);
      issue(4, 1, 32'h10, 32'h0);
      issue(7, 1, 32'h20, 32'h0);
      issue(5, 1, 32'h21, 32'h000000F0);
      issue(0, 1, 32'h21, 32'h0);
      issue(2, 1, 32'h20, 32'h0);
      issue(2, 1, 32'h02, 32'h0);
      issue(7, 1, 32'h04, 32'hCAFEBABE);
      issue(6, 1, 32'h05, 32'h00001111);
      issue(2, 1, 32'h04, 32'h0);
      issue(7, 1, 32'h10 + DEPTH*4*5, 32'hA5A55A5A);
      issue(2, 1, 32'h10, 32'h0);
      issue(8, 1, 32'h0, 32'h0);
      issue(2, 0, 32'h10, 32'h0);
      for (int w = 0; w < 16; w++) issue(7, 1, 32'(w*4), $urandom);
      for (int n = 0; n < 150; n++)
        issue($urandom_range(0, 8), $urandom_range(0, 9) != 0,
              32'($urandom_range(0, 15)*4 + $urandom_range(0, 3)*DEPTH*4 + $urandom_range(0, 3)),
              $urandom);
      m_valid  = 1'b0;
      drv_done = 1;
      for (int c = 0; c < 50 && !mon_done; c++) @(posedge clk);
      check($sformatf("cfg%0d monitor_drained", g), 32'(mon_done), 32'd1);
      // Reset during an in-flight store drops it; the old word must survive
      #1;
      keep    = mword(12);
      m_valid = 1'b1;
      m_instr = {opc(7), 26'd0};
      m_addr  = 32'h30;
      m_wdata = ~keep;
      repeat ((LAT > 0) ? 1 : 0) @(posedge clk);
      #2;
      reset   = 1'b0;
      m_valid = 1'b0;
      #1;
      check($sformatf("cfg%0d midrst_w_wd", g), w_wd, 32'd0);
      check($sformatf("cfg%0d midrst_a3_tr", g), 32'(w_a3) | 32'(tr_we) | tr_data, 32'd0);
      check($sformatf("cfg%0d midrst_stall", g), 32'(m_stall), 32'd0);
      @(posedge clk);
      #1;
      reset   = 1'b1;
      m_valid = 1'b1;
      m_instr = {opc(2), 26'd0};
      m_addr  = 32'h30;
      wait_free();
      check($sformatf("cfg%0d dropped_store", g), w_wd, keep);
      m_valid = 1'b0;
      fin[g]  = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion want both configurations done");
    $fatal(1);
  end

  initial begin
    wait (fin == 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
